i8008_bus_agent: RTL and testbench

Parametrised external-bus agent for `i8008_core`. It sits on the core's `D_out`/`Sync`/`state` side and answers with `D_in`/`READY`/`INTR`. Each cycle it:
- reassembles the 14-bit address from T1/T2,
- decodes the cycle type,
- inserts a programmable number of WAIT states,
- serves instruction/data reads from internal memory and commits writes,
- handles I/O ports and interrupt acknowledge (T1I) with a jammed RST vector.

It replaces hand-sequenced bench stimulus and is the memory model for the core's system-level benches.

---
 rtl/i8008_bus_agent.sv | 169 ++++++++++++++++
 tb/tb_i8008_bus_agent.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i8008_bus_agent.sv
// External-bus agent for i8008_core: captures the T1/T2 address, inserts WAIT states, serves
// memory and I/O, and jams an RST on interrupt acknowledge. state uses the 8008 S2..S0 encoding.
module i8008_bus_agent #(
    parameter int MEM_DEPTH    = 1024,
    parameter int WAIT_CYCLES  = 0,
    parameter int NUM_IN_PORTS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   state,
    input  logic                         Sync,
    input  logic [7:0]                   D_out,
    output logic [7:0]                   D_in,
    output logic                         READY,
    output logic                         INTR,
    input  logic                         intr_req,
    input  logic [2:0]                   intr_vector,
    input  logic [NUM_IN_PORTS-1:0][7:0] in_port_data,
    output logic                         io_out_valid,
    output logic [4:0]                   io_out_port,
    output logic [7:0]                   io_out_data,
    input  logic                         load_en,
    input  logic [13:0]                  load_addr,
    input  logic [7:0]                   load_data,
    output logic                         halted
);
    typedef enum logic [2:0] {
        ST_WAIT    = 3'b000,
        ST_T3      = 3'b001,
        ST_T1      = 3'b010,
        ST_STOPPED = 3'b011,
        ST_T2      = 3'b100,
        ST_T5      = 3'b101,
        ST_T1I     = 3'b110,
        ST_T4      = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        CYC_PCI = 2'b00,
        CYC_PCR = 2'b01,
        CYC_PCC = 2'b10,
        CYC_PCW = 2'b11
    } cyc_t;

    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t           cur_st;
    logic [7:0]       addr_lo_q, addr_lo_d;
    logic [5:0]       addr_hi_q, addr_hi_d;
    cyc_t             cyc_q, cyc_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             is_t1i_q, is_t1i_d;
    logic [7:0]       d_in_q, d_in_d;
    logic             intr_pend_q, intr_pend_d;
    logic             io_out_valid_q, io_out_valid_d;
    logic [4:0]       io_out_port_q, io_out_port_d;
    logic [7:0]       io_out_data_q, io_out_data_d;
    logic [7:0]       mem [MEM_DEPTH];

    logic             in_t1, in_t2_wait, bus_ready, pcw_commit, out_commit;
    logic [5:0]       eff_hi;
    cyc_t             eff_cyc;
    logic [13:0]      eff_addr;
    logic [IDX_W-1:0] mem_idx, load_idx;
    logic [4:0]       port_num;
    logic [7:0]       rd_data;
    logic             unused_sig;

    assign cur_st     = state_t'(state);
    assign in_t1      = (cur_st == ST_T1) || (cur_st == ST_T1I);
    assign in_t2_wait = (cur_st == ST_T2) || (cur_st == ST_WAIT);
    assign bus_ready  = rst_n && in_t2_wait && (wcnt_q == 4'd0);

    // With no WAIT states the read completes in T2, while the high byte is still on D_out
    assign eff_hi     = (cur_st == ST_T2) ? D_out[5:0] : addr_hi_q;
    assign eff_cyc    = (cur_st == ST_T2) ? cyc_t'(D_out[7:6]) : cyc_q;
    assign eff_addr   = {eff_hi, addr_lo_q};
    assign mem_idx    = eff_addr[IDX_W-1:0];
    assign load_idx   = load_addr[IDX_W-1:0];
    assign port_num   = eff_hi[5:1];
    assign pcw_commit = (cur_st == ST_T3) && (cyc_q == CYC_PCW);
    assign out_commit = (cur_st == ST_T3) && (cyc_q == CYC_PCC) && (addr_hi_q[5:4] != 2'b00);
    assign unused_sig = ^{Sync, eff_addr, load_addr};

    always_comb begin
        rd_data = 8'h00;
        case (eff_cyc)
            CYC_PCI: rd_data = is_t1i_q ? {2'b00, intr_vector, 3'b101} : mem[mem_idx];
            CYC_PCR: rd_data = mem[mem_idx];
            CYC_PCC: if (port_num < 5'd8) rd_data = in_port_data[port_num[2:0]];
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        addr_lo_d      = addr_lo_q;
        addr_hi_d      = addr_hi_q;
        cyc_d          = cyc_q;
        wcnt_d         = wcnt_q;
        is_t1i_d       = is_t1i_q;
        d_in_d         = d_in_q;
        intr_pend_d    = intr_pend_q;
        io_out_valid_d = 1'b0;
        io_out_port_d  = io_out_port_q;
        io_out_data_d  = io_out_data_q;

        if (in_t1) begin
            addr_lo_d = D_out;
            wcnt_d    = WAIT_INIT;
            is_t1i_d  = (cur_st == ST_T1I);
            d_in_d    = 8'h00;
        end
        if (cur_st == ST_T2) begin
            addr_hi_d = D_out[5:0];
            cyc_d     = cyc_t'(D_out[7:6]);
        end
        if (in_t2_wait && (wcnt_q != 4'd0)) wcnt_d = wcnt_q - 4'd1;
        if (bus_ready) d_in_d = rd_data;
        if (out_commit) begin
            io_out_valid_d = 1'b1;
            io_out_port_d  = addr_hi_q[5:1];
            io_out_data_d  = addr_lo_q;
        end
        // Acknowledge beats a still-high request; it re-pends on the following edge
        if (cur_st == ST_T1I) intr_pend_d = 1'b0;
        else if (intr_req)    intr_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q      <= 8'h00;
            addr_hi_q      <= 6'h00;
            cyc_q          <= CYC_PCI;
            wcnt_q         <= 4'd0;
            is_t1i_q       <= 1'b0;
            d_in_q         <= 8'h00;
            intr_pend_q    <= 1'b0;
            io_out_valid_q <= 1'b0;
            io_out_port_q  <= 5'd0;
            io_out_data_q  <= 8'h00;
        end else begin
            addr_lo_q      <= addr_lo_d;
            addr_hi_q      <= addr_hi_d;
            cyc_q          <= cyc_d;
            wcnt_q         <= wcnt_d;
            is_t1i_q       <= is_t1i_d;
            d_in_q         <= d_in_d;
            intr_pend_q    <= intr_pend_d;
            io_out_valid_q <= io_out_valid_d;
            io_out_port_q  <= io_out_port_d;
            io_out_data_q  <= io_out_data_d;
        end
    end

    // Core write is issued last so it overrides a same-edge backdoor load
    always_ff @(posedge clk) begin
        if (load_en)    mem[load_idx] <= load_data;
        if (pcw_commit) mem[mem_idx]  <= D_out;
    end

    assign D_in         = d_in_q;
    assign READY        = bus_ready;
    assign INTR         = intr_pend_q;
    assign io_out_valid = io_out_valid_q;
    assign io_out_port  = io_out_port_q;
    assign io_out_data  = io_out_data_q;
    assign halted       = (cur_st == ST_STOPPED);
endmodule

// File: tb/tb_i8008_bus_agent.sv
// Bench for i8008_bus_agent: two instances (0 and 3 WAIT states) share one bus; a directed
// vector table, hand-written interrupt/reset sequences and random cycles against a byte-array model.
module tb_i8008_bus_agent;
    localparam logic [2:0] S_WAIT = 3'b000, S_T3 = 3'b001, S_T1 = 3'b010, S_STOP = 3'b011,
                           S_T2 = 3'b100, S_T5 = 3'b101, S_T1I = 3'b110, S_T4 = 3'b111;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      state;
    logic            sync;
    logic [7:0]      d_out;
    logic            intr_req;
    logic [2:0]      intr_vector;
    logic [7:0][7:0] in_ports;
    logic            load_en;
    logic [13:0]     load_addr;
    logic [7:0]      load_data;

    logic [7:0] d_in0, d_in3, oport_d0, oport_d3, odata0, odata3;
    logic       ready0, ready3, intr0, intr3, oval0, oval3, halt0, halt3;
    logic [4:0] oport0, oport3;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_model [DEPTH];

    typedef struct {
        logic        t1i;
        logic [1:0]  cyc;
        logic [13:0] addr;
        logic [7:0]  t3_byte;
        int          nwait;
        logic [7:0]  exp_data;
        logic        exp_out;
        logic [4:0]  exp_port;
        logic        collide;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    assign oport_d0 = {3'b000, oport0};
    assign oport_d3 = {3'b000, oport3};

    i8008_bus_agent #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(0), .NUM_IN_PORTS(8)) u_w0 (
        .clk(clk), .rst_n(rst_n), .state(state), .Sync(sync), .D_out(d_out), .D_in(d_in0),
        .READY(ready0), .INTR(intr0), .intr_req(intr_req), .intr_vector(intr_vector),
        .in_port_data(in_ports), .io_out_valid(oval0), .io_out_port(oport0), .io_out_data(odata0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .halted(halt0)
    );

    i8008_bus_agent #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(3), .NUM_IN_PORTS(8)) u_w3 (
        .clk(clk), .rst_n(rst_n), .state(state), .Sync(sync), .D_out(d_out), .D_in(d_in3),
        .READY(ready3), .INTR(intr3), .intr_req(intr_req), .intr_vector(intr_vector),
        .in_port_data(in_ports), .io_out_valid(oval3), .io_out_port(oport3), .io_out_data(odata3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .halted(halt3)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] st, input logic [7:0] dout);
        @(negedge clk);
        state = st;
        d_out = dout;
        #1;
    endtask

    // Reference read value of a bus cycle, straight from the cycle-type rules
    function automatic logic [7:0] model_read(input vec_t v);
        int port = int'(v.addr[13:9]);
        case (v.cyc)
            2'b00:   return v.t1i ? {2'b00, intr_vector, 3'b101} : mem_model[int'(v.addr) % DEPTH];
            2'b01:   return mem_model[int'(v.addr) % DEPTH];
            2'b10:   return (port < 8) ? in_ports[port] : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic bus_cycle(input vec_t v);
        apply_stimulus(v.t1i ? S_T1I : S_T1, v.addr[7:0]);
        check_output("ready_t1_w0", ready0, 0);
        check_output("ready_t1_w3", ready3, 0);
        check_output("halted_t1", halt0, 0);
        for (int k = 0; k <= v.nwait; k++) begin
            apply_stimulus((k == 0) ? S_T2 : S_WAIT, (k == 0) ? {v.cyc, v.addr[13:8]} : 8'($urandom));
            check_output("ready_w0", ready0, 1);
            check_output("ready_w3", ready3, (k >= 3) ? 1 : 0);
        end
        @(negedge clk);
        state = S_T3;
        d_out = v.t3_byte;
        if (v.collide) begin
            load_en   = 1'b1;
            load_addr = v.addr;
            load_data = 8'h11;
        end
        #1;
        check_output("ready_t3_w0", ready0, 0);
        check_output("d_in_t3_w0", d_in0, v.exp_data);
        check_output("d_in_t3_w3", d_in3, (v.nwait >= 3) ? v.exp_data : 8'h00);
        check_output("oval_t3", oval0, 0);
        if (v.cyc == 2'b11) mem_model[int'(v.addr) % DEPTH] = v.t3_byte;
        apply_stimulus(S_T4, 8'($urandom));
        load_en = 1'b0;
        check_output("oval_t4_w0", oval0, v.exp_out);
        check_output("oval_t4_w3", oval3, v.exp_out);
        if (v.exp_out) begin
            check_output("oport_w0", oport_d0, {3'b000, v.exp_port});
            check_output("oport_w3", oport_d3, {3'b000, v.exp_port});
            check_output("odata_w0", odata0, v.addr[7:0]);
            check_output("odata_w3", odata3, v.addr[7:0]);
        end
        apply_stimulus(S_T5, 8'($urandom));
        check_output("oval_t5", oval0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; state = S_T1; sync = 1'b0; d_out = 8'h00; intr_req = 1'b0;
        intr_vector = 3'b000; in_ports = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        #2;
        check_output("rst_d_in", {d_in0, d_in3}, 0);
        check_output("rst_intr", {intr0, intr3}, 0);
        check_output("rst_oval", {oval0, oval3}, 0);
        check_output("rst_oport", {oport0, oport3}, 0);
        check_output("rst_odata", {odata0, odata3}, 0);
        check_output("rst_ready", {ready0, ready3}, 0);
        state = S_STOP;
        #1;
        check_output("rst_halted", {halt0, halt3}, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        state = S_T4;

        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'($urandom);
        mem_model[0] = 8'h08;
        mem_model[1] = 8'hFF;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 14'(i);
            load_data = mem_model[i];
        end
        @(negedge clk);
        load_en = 1'b0;
        for (int p = 0; p < 8; p++) in_ports[p] = 8'($urandom);
        in_ports[3] = 8'h5C;

        tbl[0] = '{1'b0, 2'b00, 14'h0000, 8'h00, 0, 8'h08, 1'b0, 5'd0,  1'b0};
        tbl[1] = '{1'b0, 2'b00, 14'h0001, 8'h00, 0, 8'hFF, 1'b0, 5'd0,  1'b0};
        tbl[2] = '{1'b0, 2'b00, 14'h0000, 8'h00, 3, 8'h08, 1'b0, 5'd0,  1'b0};
        tbl[3] = '{1'b0, 2'b11, 14'h0405, 8'hA5, 3, 8'h00, 1'b0, 5'd0,  1'b0};
        tbl[4] = '{1'b0, 2'b01, 14'h0005, 8'h00, 3, 8'hA5, 1'b0, 5'd0,  1'b0};
        tbl[5] = '{1'b0, 2'b10, 14'h0777, 8'h00, 1, 8'h5C, 1'b0, 5'd0,  1'b0};
        tbl[6] = '{1'b0, 2'b10, 14'h233E, 8'h00, 3, 8'h00, 1'b1, 5'd17, 1'b0};
        tbl[7] = '{1'b0, 2'b11, 14'h0005, 8'h22, 0, 8'h00, 1'b0, 5'd0,  1'b1};
        tbl[8] = '{1'b0, 2'b01, 14'h0405, 8'h00, 4, 8'h22, 1'b0, 5'd0,  1'b0};
        for (int i = 0; i < 9; i++) bus_cycle(tbl[i]);

        apply_stimulus(S_STOP, 8'h00);
        check_output("halted_stop", {halt0, halt3}, 2'b11);
        check_output("intr_idle", {intr0, intr3}, 0);

        // Wake from halt with a jammed RST 2
        intr_req = 1'b1;
        intr_vector = 3'b010;
        apply_stimulus(S_STOP, 8'h00);
        apply_stimulus(S_STOP, 8'h00);
        check_output("intr_set", {intr0, intr3}, 2'b11);
        intr_req = 1'b0;
        bus_cycle('{1'b1, 2'b00, 14'h0002, 8'h00, 3, 8'h15, 1'b0, 5'd0, 1'b0});
        check_output("intr_dropped", {intr0, intr3}, 0);

        // Request held through acknowledge re-pends one cycle later
        intr_req = 1'b1;
        apply_stimulus(S_STOP, 8'h00);
        apply_stimulus(S_STOP, 8'h00);
        apply_stimulus(S_T1I, 8'h02);
        check_output("intr_in_t1i", intr0, 1);
        apply_stimulus(S_T2, 8'h00);
        check_output("intr_after_ack", intr0, 0);
        apply_stimulus(S_WAIT, 8'h00);
        check_output("intr_reassert", intr0, 1);
        intr_req = 1'b0;
        apply_stimulus(S_T3, 8'h00);
        apply_stimulus(S_T4, 8'h00);
        apply_stimulus(S_T5, 8'h00);
        intr_vector = 3'b111;
        bus_cycle('{1'b1, 2'b00, 14'h0003, 8'h00, 3, 8'h3D, 1'b0, 5'd0, 1'b0});
        check_output("intr_cleared", {intr0, intr3}, 0);

        for (int n = 0; n < 80; n++) begin
            int kind;
            int port;
            kind = $urandom_range(0, 5);
            for (int p = 0; p < 8; p++) in_ports[p] = 8'($urandom);
            intr_vector = 3'($urandom);
            v.t1i = 1'b0; v.exp_out = 1'b0; v.exp_port = 5'd0; v.collide = 1'b0;
            v.addr = 14'($urandom);
            v.nwait = $urandom_range(0, 4);
            v.t3_byte = 8'($urandom);
            case (kind)
                0:       v.cyc = 2'b00;
                1:       begin v.cyc = 2'b00; v.t1i = 1'b1; end
                2:       v.cyc = 2'b01;
                3:       v.cyc = 2'b11;
                default: begin
                    v.cyc = 2'b10;
                    port = $urandom_range(0, 31);
                    v.addr[13:9] = 5'(port);
                    v.exp_out = (port >= 8);
                    v.exp_port = 5'(port);
                end
            endcase
            v.exp_data = model_read(v);
            bus_cycle(v);
        end

        // Reset asserted in the middle of a WAIT state
        intr_req = 1'b1;
        apply_stimulus(S_T5, 8'h00);
        apply_stimulus(S_T5, 8'h00);
        apply_stimulus(S_T1, 8'h00);
        apply_stimulus(S_T2, 8'h00);
        apply_stimulus(S_WAIT, 8'h00);
        check_output("pre_rst_d_in", d_in0, mem_model[0]);
        check_output("pre_rst_intr", intr0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midrst_ready", {ready0, ready3}, 0);
        check_output("midrst_d_in", {d_in0, d_in3}, 0);
        check_output("midrst_intr", {intr0, intr3}, 0);
        check_output("midrst_oport", {oport0, oport3}, 0);
        intr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        state = S_T5;
        bus_cycle('{1'b0, 2'b00, 14'h0001, 8'h00, 3, mem_model[1], 1'b0, 5'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
